// File: rtl/stall_controller_pkg.sv
// rtl/stall_controller_pkg.sv - shared pipeline-control types and defaults
package stall_controller_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int CNT_WIDTH_DEFAULT      = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Wait counter must hold TIMEOUT_CYCLES itself without wrapping.
  function automatic int wait_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stall_controller_if.sv
// rtl/stall_controller_if.sv - data memory request/acknowledge handshake
interface stall_controller_if;

  logic mem_req_o;
  logic mem_ack_i;

  modport slave (output mem_req_o, input mem_ack_i);
  modport master (input mem_req_o, output mem_ack_i);

endinterface

// File: rtl/stall_controller_load_use_detect.sv
// rtl/stall_controller_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect (
  input  logic       MemRead_EX_i,
  input  logic [4:0] RDaddr_EX_i,
  input  logic [4:0] RS1addr_ID_i,
  input  logic [4:0] RS2addr_ID_i,
  output logic       hazard_o
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard_o = MemRead_EX_i && (RDaddr_EX_i != 5'd0) &&
                    ((RDaddr_EX_i == RS1addr_ID_i) || (RDaddr_EX_i == RS2addr_ID_i));

endmodule

// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - pipeline stall/flush control with memory-wait FSM
module stall_controller
  import stall_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  stall_controller_if.slave    mem_if,
  input  logic                 MemRead_EX_i,
  input  logic [4:0]           RDaddr_EX_i,
  input  logic [4:0]           RS1addr_ID_i,
  input  logic [4:0]           RS2addr_ID_i,
  input  logic                 Branch_taken_ID_i,
  input  logic                 MemReq_MEM_i,
  output logic                 Freeze_o,
  output logic                 PCWrite_o,
  output logic                 IFID_Stall_o,
  output logic                 IFID_Flush_o,
  output logic                 NoOP_o,
  output logic                 Error_o,
  output logic [CNT_WIDTH-1:0] StallCycles_o
);

  localparam int WAIT_W = wait_cnt_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 error_q;
  logic                 hazard;
  logic                 freeze;
  logic                 mem_req;

  load_use_detect u_load_use_detect (
    .MemRead_EX_i (MemRead_EX_i),
    .RDaddr_EX_i  (RDaddr_EX_i),
    .RS1addr_ID_i (RS1addr_ID_i),
    .RS2addr_ID_i (RS2addr_ID_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    mem_req    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_req = MemReq_MEM_i;
        if (MemReq_MEM_i && !mem_if.mem_ack_i) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_if.mem_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Freeze outranks the hazard bubble, which outranks a taken-branch flush.
  always_comb begin
    PCWrite_o    = 1'b1;
    IFID_Stall_o = 1'b0;
    IFID_Flush_o = 1'b0;
    NoOP_o       = 1'b0;
    if (freeze) begin
      PCWrite_o    = 1'b0;
      IFID_Stall_o = 1'b1;
    end else if (hazard) begin
      PCWrite_o    = 1'b0;
      IFID_Stall_o = 1'b1;
      NoOP_o       = 1'b1;
    end else if (Branch_taken_ID_i) begin
      IFID_Flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= (state_d == ST_ERROR);
      if (!PCWrite_o && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign mem_if.mem_req_o = mem_req;
  assign Freeze_o         = freeze;
  assign Error_o          = error_q;
  assign StallCycles_o    = stall_cnt_q;

endmodule

// File: tb/tb_stall_controller.sv
// tb/tb_stall_controller.sv - directed self-checking bench for stall_controller
module tb_stall_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0, branch = 1'b0, memreq = 1'b0, mem_ack = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       freeze, pcw, stl, fl, nop, err;
  logic [31:0] sc;
  logic       freeze2, pcw2, stl2, fl2, nop2, err2;
  logic [1:0] sc2;
  int total = 0;
  int bad = 0;

  stall_controller_if mif ();
  stall_controller_if mif2 ();
  assign mif.mem_ack_i  = mem_ack;
  assign mif2.mem_ack_i = mem_ack;

  always #5 clk = ~clk;

  stall_controller dut (
    .clk_i(clk), .rst_i(rst), .mem_if(mif),
    .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd), .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2),
    .Branch_taken_ID_i(branch), .MemReq_MEM_i(memreq),
    .Freeze_o(freeze), .PCWrite_o(pcw), .IFID_Stall_o(stl), .IFID_Flush_o(fl),
    .NoOP_o(nop), .Error_o(err), .StallCycles_o(sc)
  );

  // Small instance exercises counter saturation and a short timeout.
  stall_controller #(.TIMEOUT_CYCLES(3), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .mem_if(mif2),
    .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd), .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2),
    .Branch_taken_ID_i(branch), .MemReq_MEM_i(memreq),
    .Freeze_o(freeze2), .PCWrite_o(pcw2), .IFID_Stall_o(stl2), .IFID_Flush_o(fl2),
    .NoOP_o(nop2), .Error_o(err2), .StallCycles_o(sc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; branch = 1'b0; memreq = 1'b0; mem_ack = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    total++; if (pcw !== 1'b1) begin bad++; $display("FAIL rst_pcwrite got=%0b want=1", pcw); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze got=%0b want=0", freeze); end
    total++; if ({stl, fl, nop} !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b want=000", {stl, fl, nop}); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_error got=%0b want=0", err); end
    total++; if (sc !== 32'd0) begin bad++; $display("FAIL rst_stallcnt got=%0d want=0", sc); end
    total++; if (mif.mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_memreq0 got=%0b want=0", mif.mem_req_o); end
    memreq = 1'b1;
    #1;
    total++; if (mif.mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_memreq_follow got=%0b want=1", mif.mem_req_o); end
    memreq = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    apply_reset();
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    #1;
    total++; if ({pcw, stl, nop, fl} !== 4'b0110) begin bad++; $display("FAIL lu_rs2_ctrl got=%b want=0110", {pcw, stl, nop, fl}); end
    tick();
    total++; if (sc !== 32'd1) begin bad++; $display("FAIL lu_stallcnt got=%0d want=1", sc); end
    rs1 = 5'd5; rs2 = 5'd7;
    #1;
    total++; if ({pcw, nop} !== 2'b01) begin bad++; $display("FAIL lu_rs1_ctrl got=%b want=01", {pcw, nop}); end
    tick();
    total++; if (sc !== 32'd2) begin bad++; $display("FAIL lu_stallcnt2 got=%0d want=2", sc); end
    tick(); tick();
    total++; if (sc !== 32'd4) begin bad++; $display("FAIL lu_stallcnt4 got=%0d want=4", sc); end
    total++; if (sc2 !== 2'd3) begin bad++; $display("FAIL sat_stallcnt got=%0d want=3", sc2); end
    clear_inputs();
  endtask

  task automatic test_x0();
    apply_reset();
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0;
    #1;
    total++; if ({pcw, stl, nop} !== 3'b100) begin bad++; $display("FAIL x0_ctrl got=%b want=100", {pcw, stl, nop}); end
    mem_read = 1'b0; rd = 5'd9; rs1 = 5'd9;
    #1;
    total++; if ({pcw, nop} !== 2'b10) begin bad++; $display("FAIL noload_ctrl got=%b want=10", {pcw, nop}); end
    tick();
    total++; if (sc !== 32'd0) begin bad++; $display("FAIL x0_stallcnt got=%0d want=0", sc); end
    clear_inputs();
  endtask

  task automatic test_branch();
    apply_reset();
    branch = 1'b1;
    #1;
    total++; if ({pcw, stl, nop, fl} !== 4'b1001) begin bad++; $display("FAIL br_ctrl got=%b want=1001", {pcw, stl, nop, fl}); end
    tick();
    total++; if (sc !== 32'd0) begin bad++; $display("FAIL br_stallcnt got=%0d want=0", sc); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    memreq = 1'b1;
    #1;
    total++; if ({freeze, mif.mem_req_o, pcw} !== 3'b110) begin bad++; $display("FAIL mw_c1 got=%b want=110", {freeze, mif.mem_req_o, pcw}); end
    tick();
    total++; if ({freeze, mif.mem_req_o} !== 2'b11) begin bad++; $display("FAIL mw_c2 got=%b want=11", {freeze, mif.mem_req_o}); end
    tick();
    total++; if ({freeze, mif.mem_req_o} !== 2'b11) begin bad++; $display("FAIL mw_c3 got=%b want=11", {freeze, mif.mem_req_o}); end
    tick();
    mem_ack = 1'b1;
    #1;
    total++; if ({freeze, mif.mem_req_o, pcw} !== 3'b011) begin bad++; $display("FAIL mw_ack got=%b want=011", {freeze, mif.mem_req_o, pcw}); end
    tick();
    memreq = 1'b0; mem_ack = 1'b0;
    #1;
    total++; if ({freeze, mif.mem_req_o} !== 2'b00) begin bad++; $display("FAIL mw_idle got=%b want=00", {freeze, mif.mem_req_o}); end
    total++; if (sc !== 32'd3) begin bad++; $display("FAIL mw_stallcnt got=%0d want=3", sc); end
    memreq = 1'b1; mem_ack = 1'b1;
    #1;
    total++; if ({freeze, mif.mem_req_o} !== 2'b01) begin bad++; $display("FAIL zw_ctrl got=%b want=01", {freeze, mif.mem_req_o}); end
    tick();
    memreq = 1'b0; mem_ack = 1'b0;
    #1;
    total++; if ({freeze, sc} !== {1'b0, 32'd3}) begin bad++; $display("FAIL zw_after got=%0b/%0d want=0/3", freeze, sc); end
    clear_inputs();
  endtask

  task automatic test_priority();
    apply_reset();
    memreq = 1'b1; mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; branch = 1'b1;
    #1;
    total++; if ({freeze, pcw, stl, nop, fl} !== 5'b10100) begin bad++; $display("FAIL pri_freeze got=%b want=10100", {freeze, pcw, stl, nop, fl}); end
    tick();
    mem_ack = 1'b1;
    #1;
    total++; if ({freeze, pcw, stl, nop, fl} !== 5'b00110) begin bad++; $display("FAIL pri_hazard got=%b want=00110", {freeze, pcw, stl, nop, fl}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    memreq = 1'b1;
    #1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 3) begin
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL to2_early got=%0b want=0", err2); end
      end
      if (k == 4) begin
        total++; if ({err2, mif2.mem_req_o} !== 2'b10) begin bad++; $display("FAIL to2_err got=%b want=10", {err2, mif2.mem_req_o}); end
      end
      if (k == 255) begin
        total++; if ({err, freeze, mif.mem_req_o} !== 3'b011) begin bad++; $display("FAIL to_before got=%b want=011", {err, freeze, mif.mem_req_o}); end
      end
    end
    total++; if ({err, freeze, mif.mem_req_o, pcw} !== 4'b1100) begin bad++; $display("FAIL to_err got=%b want=1100", {err, freeze, mif.mem_req_o, pcw}); end
    mem_ack = 1'b1;
    #1;
    total++; if ({freeze, mif.mem_req_o} !== 2'b10) begin bad++; $display("FAIL to_ack_ign got=%b want=10", {freeze, mif.mem_req_o}); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b want=1", err); end
    total++; if (sc !== 32'd257) begin bad++; $display("FAIL to_stallcnt got=%0d want=257", sc); end
    clear_inputs();
    #1;
    rst = 1'b1;
    #1;
    total++; if ({err, freeze, sc} !== {2'b00, 32'd0}) begin bad++; $display("FAIL to_rst got=%0b/%0b/%0d want=0/0/0", err, freeze, sc); end
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    memreq = 1'b1;
    #1;
    tick();
    tick();
    total++; if (sc !== 32'd2) begin bad++; $display("FAIL ar_pre got=%0d want=2", sc); end
    #2;
    rst = 1'b1;
    #2;
    total++; if ({err, sc} !== {1'b0, 32'd0}) begin bad++; $display("FAIL ar_cnt got=%0b/%0d want=0/0", err, sc); end
    memreq = 1'b0;
    #1;
    total++; if ({freeze, mif.mem_req_o, pcw} !== 3'b001) begin bad++; $display("FAIL ar_idle got=%b want=001", {freeze, mif.mem_req_o, pcw}); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_priority();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
